// File: rtl/alu_pkg.sv
// Shared opcode values, default opcode width and FSM state encoding for seq_alu.
// REM (opcode 15) is only legal when the design is built with ALU_REM_EN defined.
package alu_pkg;

   localparam int ALU_OP_W = 16;

   localparam int ALU_ADD  = 11;
   localparam int ALU_SUB  = 12;
   localparam int ALU_MULT = 13;
   localparam int ALU_DIV  = 14;
   localparam int ALU_REM  = 15;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DIV  = 2'd1,
      ST_DONE = 2'd2
   } alu_state_e;

endpackage

// File: rtl/seq_divider.sv
// Restoring shift-subtract divider: one quotient bit per cycle, WIDTH cycles per divide.
// The remainder port exists only when ALU_REM_EN is defined.
module seq_divider
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient
`ifdef ALU_REM_EN
   ,
   output logic [WIDTH-1:0] remainder
`endif
);

   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   // quo carries the unconsumed dividend bits in its top end while quotient bits fill from the bottom
   function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] rem,
                                                    input logic [WIDTH-1:0] quo,
                                                    input logic [WIDTH-1:0] dvs);
      logic [WIDTH:0] part;
      logic [WIDTH:0] diff;
      part = {rem, quo[WIDTH-1]};
      diff = part - {1'b0, dvs};
      if (part >= {1'b0, dvs}) begin
         div_step = {diff[WIDTH-1:0], quo[WIDTH-2:0], 1'b1};
      end else begin
         div_step = {part[WIDTH-1:0], quo[WIDTH-2:0], 1'b0};
      end
   endfunction

   // The first step is taken on the start edge so the final bit is ready WIDTH-1 edges later
   always_comb begin
      rem_d  = rem_q;
      quo_d  = quo_q;
      dvs_d  = dvs_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      done_d = 1'b0;
      if (start) begin
         {rem_d, quo_d} = div_step({WIDTH{1'b0}}, dividend, divisor);
         dvs_d  = divisor;
         cnt_d  = CNT_W'(1'b1);
         busy_d = 1'b1;
      end else if (busy_q) begin
         {rem_d, quo_d} = div_step(rem_q, quo_q, dvs_q);
         if (cnt_q == CNT_W'(WIDTH - 1)) begin
            cnt_d  = {CNT_W{1'b0}};
            busy_d = 1'b0;
            done_d = 1'b1;
         end else begin
            cnt_d  = cnt_q + CNT_W'(1'b1);
            busy_d = 1'b1;
         end
      end else begin
         busy_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_q  <= {WIDTH{1'b0}};
         quo_q  <= {WIDTH{1'b0}};
         dvs_q  <= {WIDTH{1'b0}};
         cnt_q  <= {CNT_W{1'b0}};
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         rem_q  <= rem_d;
         quo_q  <= quo_d;
         dvs_q  <= dvs_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign quotient = quo_q;
`ifdef ALU_REM_EN
   assign remainder = rem_q;
`endif

endmodule

// File: rtl/seq_alu.sv
// Registered unsigned ALU with valid/ready handshakes, one operation in flight, and an
// iterative divider. Define ALU_REM_EN to make opcode 15 (REM) legal.
module seq_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int OP_W  = ALU_OP_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [OP_W-1:0]  op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] r,
   output logic             err
);

   alu_state_e       state_q, state_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic             err_q, err_d;
   logic             div_start_s;
   logic             div_busy_s;
   logic             div_done_s;
   logic [WIDTH-1:0] div_quo_s;
`ifdef ALU_REM_EN
   logic [WIDTH-1:0] div_rem_s;
   logic             rem_sel_q, rem_sel_d;
`endif

   seq_divider #(.WIDTH(WIDTH)) u_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (div_start_s),
      .dividend (a),
      .divisor  (b),
      .busy     (div_busy_s),
      .done     (div_done_s),
      .quotient (div_quo_s)
`ifdef ALU_REM_EN
      ,
      .remainder(div_rem_s)
`endif
   );

   always_comb begin
      state_d     = state_q;
      r_d         = r_q;
      err_d       = err_q;
      div_start_s = 1'b0;
`ifdef ALU_REM_EN
      rem_sel_d   = rem_sel_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               state_d = ST_DONE;
               err_d   = 1'b0;
               case (op)
                  OP_W'(ALU_ADD):  r_d = a + b;
                  OP_W'(ALU_SUB):  r_d = a - b;
                  OP_W'(ALU_MULT): r_d = a * b;
                  OP_W'(ALU_DIV): begin
                     if (b == {WIDTH{1'b0}}) begin
                        r_d   = {WIDTH{1'b1}};
                        err_d = 1'b1;
                     end else begin
                        state_d     = ST_DIV;
                        div_start_s = 1'b1;
`ifdef ALU_REM_EN
                        rem_sel_d   = 1'b0;
`endif
                     end
                  end
`ifdef ALU_REM_EN
                  OP_W'(ALU_REM): begin
                     if (b == {WIDTH{1'b0}}) begin
                        r_d   = a;
                        err_d = 1'b1;
                     end else begin
                        state_d     = ST_DIV;
                        div_start_s = 1'b1;
                        rem_sel_d   = 1'b1;
                     end
                  end
`endif
                  default: begin
                     r_d   = {WIDTH{1'b0}};
                     err_d = 1'b1;
                  end
               endcase
            end else begin
               state_d = ST_IDLE;
            end
         end
         // A divider that stops without signalling done abandons the operation
         ST_DIV: begin
            if (div_done_s) begin
               state_d = ST_DONE;
               err_d   = 1'b0;
`ifdef ALU_REM_EN
               if (rem_sel_q) begin
                  r_d = div_rem_s;
               end else begin
                  r_d = div_quo_s;
               end
`else
               r_d = div_quo_s;
`endif
            end else if (!div_busy_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DIV;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         r_q     <= {WIDTH{1'b0}};
         err_q   <= 1'b0;
`ifdef ALU_REM_EN
         rem_sel_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         err_q   <= err_d;
`ifdef ALU_REM_EN
         rem_sel_q <= rem_sel_d;
`endif
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign r         = r_q;
   assign err       = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: driver pushes expected results, a monitor pops and compares
// them (value, error flag, latency, hold stability). Honours ALU_REM_EN for opcode 15.
module tb_seq_alu;

   localparam int W = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a, b;
   logic [15:0]   op;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  r;
   logic          err;

   logic or_mode, or_fixed, or_rnd;

   typedef struct {
      logic [W-1:0] r;
      logic         err;
      int           lat;
      int           acc;
   } exp_t;

   exp_t sb[$];
   int   nchk = 0;
   int   nfail = 0;
   int   cyc = 0;
   logic seen = 1'b0;
   logic [W-1:0] hold_r;
   logic         hold_err;

   seq_alu #(.WIDTH(W), .OP_W(16)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .b        (b),
      .op       (op),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .r        (r),
      .err      (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(posedge clk) begin
      #2;
      or_rnd = 1'($urandom_range(0, 1));
   end

   assign out_ready = or_mode ? or_rnd : or_fixed;

   task automatic chk(input string name, input longint act, input longint expv);
      nchk++;
      if (act != expv) begin
         nfail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                  name, act, act, expv, expv, cyc);
      end
   endtask

   // Reference model: plain integer arithmetic modulo 2^W
   function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                  input logic [15:0] iop);
      longint ua, ub, m;
      exp_t e;
      ua = ia; ub = ib; m = longint'(1) << W;
      e.err = 1'b0; e.lat = 1; e.acc = 0;
      case (int'(iop))
         11: e.r = W'((ua + ub) % m);
         12: e.r = W'((ua - ub + m) % m);
         13: e.r = W'((ua * ub) % m);
         14: if (ub == 0) begin e.r = W'(m - 1); e.err = 1'b1; end
             else begin e.r = W'(ua / ub); e.lat = W + 1; end
`ifdef ALU_REM_EN
         15: if (ub == 0) begin e.r = ia; e.err = 1'b1; end
             else begin e.r = W'(ua % ub); e.lat = W + 1; end
`endif
         default: begin e.r = '0; e.err = 1'b1; end
      endcase
      return e;
   endfunction

   task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [15:0] iop,
                        input logic [W-1:0] er, input logic eerr, input int elat);
      int w;
      exp_t e;
      @(negedge clk);
      in_valid = 1'b1; a = ia; b = ib; op = iop;
      w = 0;
      while (!in_ready && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (!in_ready) begin
         nchk++; nfail++;
         $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, expected 1", w);
         in_valid = 1'b0;
      end else begin
         e.r = er; e.err = eerr; e.lat = elat; e.acc = cyc + 1;
         sb.push_back(e);
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         a = W'($urandom); b = W'($urandom); op = 16'($urandom);
      end
   endtask

   task automatic issue_rand(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [15:0] iop);
      exp_t e;
      e = model(ia, ib, iop);
      issue(ia, ib, iop, e.r, e.err, e.lat);
   endtask

   task automatic wait_idle();
      int w;
      w = 0;
      @(negedge clk);
      while ((sb.size() != 0 || !in_ready) && w < 300) begin
         @(negedge clk);
         w++;
      end
      if (sb.size() != 0 || !in_ready) begin
         nchk++; nfail++;
         $display("FAIL drain_timeout: %0d results outstanding, in_ready=%0b, expected 0 and 1",
                  sb.size(), in_ready);
      end
   endtask

   // Monitor: latency on first sight of out_valid, hold stability, result on transfer
   always @(negedge clk) begin
      #1;
      if (!rst_n) begin
         seen = 1'b0;
      end else if (out_valid) begin
         if (!seen) begin
            seen = 1'b1;
            hold_r = r;
            hold_err = err;
            if (sb.size() == 0) begin
               nchk++; nfail++;
               $display("FAIL unexpected_output: r=0x%0h err=%0b with no request outstanding", r, err);
            end else begin
               chk("latency", longint'(cyc - sb[0].acc + 1), longint'(sb[0].lat));
            end
         end else begin
            chk("r_stable", r, hold_r);
            chk("err_stable", err, hold_err);
         end
         if (out_ready) begin
            if (sb.size() != 0) begin
               chk("result_r", r, sb[0].r);
               chk("result_err", err, sb[0].err);
               void'(sb.pop_front());
            end
            seen = 1'b0;
         end
      end
   end

   initial begin
      logic [W-1:0] ra, rb;
      logic [15:0]  rop;
      int           sel;
      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = '0;
      or_mode = 1'b0; or_fixed = 1'b1;

      #12;
      chk("reset_in_ready", in_ready, 1);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_r", r, 0);
      chk("reset_err", err, 0);
      @(negedge clk); #3; rst_n = 1'b1;

      issue(16'hFFFF, 16'h0002, 16'd11, 16'h0001, 1'b0, 1);
      issue(16'd3, 16'd5, 16'd12, 16'hFFFE, 1'b0, 1);
      issue(16'h0100, 16'h0100, 16'd13, 16'h0000, 1'b0, 1);
      issue(16'd5, 16'd0, 16'd14, 16'hFFFF, 1'b1, 1);
      issue(16'd1234, 16'd55, 16'd9, 16'h0000, 1'b1, 1);
      wait_idle();

      // DIV with a stray request pulsed while the divider runs
      issue(16'd1000, 16'd7, 16'd14, 16'd142, 1'b0, 17);
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         chk("div_in_ready", in_ready, 0);
         chk("div_out_valid", out_valid, 0);
         if (i == 4) begin in_valid = 1'b1; a = 16'd1; b = 16'd1; op = 16'd11; end
         if (i == 5) in_valid = 1'b0;
      end
      wait_idle();

`ifdef ALU_REM_EN
      issue(16'd1000, 16'd7, 16'd15, 16'd6, 1'b0, 17);
      issue(16'd77, 16'd0, 16'd15, 16'd77, 1'b1, 1);
`else
      issue(16'd1000, 16'd7, 16'd15, 16'h0000, 1'b1, 1);
`endif
      wait_idle();

      // Backpressure: hold the result 10 cycles, then release for one cycle
      or_fixed = 1'b0;
      issue(16'h1234, 16'h0001, 16'd11, 16'h1235, 1'b0, 1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_out_valid", out_valid, 1);
         chk("bp_in_ready", in_ready, 0);
      end
      @(negedge clk); or_fixed = 1'b1;
      @(negedge clk); or_fixed = 1'b0;
      chk("bp_release_in_ready", in_ready, 1);
      chk("bp_release_out_valid", out_valid, 0);
      or_fixed = 1'b1;
      wait_idle();

      // Asynchronous reset in the middle of a divide
      issue(16'd1000, 16'd7, 16'd14, 16'd142, 1'b0, 17);
      repeat (7) @(negedge clk);
      #3; rst_n = 1'b0;
      #1;
      chk("abort_out_valid", out_valid, 0);
      chk("abort_in_ready", in_ready, 1);
      chk("abort_r", r, 0);
      chk("abort_err", err, 0);
      sb.delete();
      @(negedge clk); #3; rst_n = 1'b1;
      issue(16'd2, 16'd2, 16'd11, 16'd4, 1'b0, 1);
      wait_idle();

      // Random traffic with random consumer stalls
      or_mode = 1'b1;
      for (int n = 0; n < 60; n++) begin
         sel = int'($urandom_range(0, 7));
         ra = W'($urandom);
         rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
         if (sel == 7) rb = W'($urandom_range(1, 9));
         case (sel)
            5:       rop = 16'd9;
            6:       rop = 16'($urandom);
            7:       rop = 16'd14;
            default: rop = 16'(11 + sel);
         endcase
         issue_rand(ra, rb, rop);
      end
      wait_idle();

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor of the team's 16-bit combinational calculator ALU.
- Adds a valid/ready handshake on input and output, a multi-cycle iterative divider, and an error flag for divide-by-zero and illegal opcodes.
- Sits between the keypad/operand controller and the display formatter.
- Exactly one operation is in flight at a time.

Parameters:
- WIDTH, 16, operand and result width in bits (≥2).
- OP_W, 16, opcode width; opcode values come from the shared package.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands and op presented.
- in_ready  out  1  block can accept an operation.
- a  in  WIDTH  operand A, unsigned.
- b  in  WIDTH  operand B, unsigned.
- op  in  OP_W  opcode: ADD=11, SUB=12, MULT=13, DIV=14.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- r  out  WIDTH  result.
- err  out  1  result is an error (divide-by-zero or illegal op).

Behaviour:
- Interface: one clock clk, asynchronous active-low reset rst_n.
- Reset: state=IDLE; in_ready=1; out_valid=0; r=0; err=0; divider registers cleared.
- Reset mid-division aborts the operation with no output.
- Accept: occurs on a rising edge with in_valid && in_ready. a, b and op are captured on that edge, and later input changes are ignored.
- States and transitions:
  - IDLE: in_ready=1. Accepted ADD/SUB/MULT/illegal → DONE. Accepted DIV with b≠0 → DIV. Accepted DIV with b==0 → DONE.
  - DIV: restoring shift-subtract, one quotient bit per cycle, exactly WIDTH cycles; then → DONE.
  - DONE: out_valid=1; r and err held stable until out_ready. out_valid && out_ready → IDLE.
- in_ready is 0 in DIV and DONE. There is no combinational ready pass-through, so throughput is at most one operation per 2 cycles.
- Latency (accept edge to out_valid high): 1 cycle for ADD/SUB/MULT/illegal/div-by-zero; WIDTH+1 cycles for DIV.
- Arithmetic, modulo 2^WIDTH:
  - ADD = a+b, carry discarded.
  - SUB = a-b, wraps (0-1 = all ones).
  - MULT = low WIDTH bits of the 2·WIDTH product.
  - DIV = floor(a/b).
- Divide-by-zero: r = all ones, err=1.
- Illegal opcode: r=0, err=1.
- err=0 for every legal, non-zero-divisor result.
- out_ready held high before DONE has no effect.
- in_valid asserted while in_ready=0 is ignored. The producer must hold the request until accepted.

Optional Feature:
- Macro: ALU_REM_EN.
- Defined: opcode 15 = REM, r = a mod b, computed by the same divider with identical latency (WIDTH+1). REM with b==0 gives r=a, err=1.
- Undefined: opcode 15 is illegal (r=0, err=1, 1-cycle latency) and the remainder output path is not built.

Decomposition:
- Package alu_pkg:
  - opcode localparams ALU_ADD=11, ALU_SUB=12, ALU_MULT=13, ALU_DIV=14, ALU_REM=15;
  - state encoding IDLE/DIV/DONE;
  - default OP_W.
- Sub-module seq_divider (WIDTH parameter):
  - ports: start, dividend, divisor → busy, done, quotient, remainder;
  - owns the iteration counter;
  - seq_alu instantiates one and handles the zero-divisor check itself.

Test Plan (WIDTH=16 unless noted):
- ADD a=0xFFFF, b=0x0002; out_ready=1 → out_valid one cycle after accept; r=0x0001, err=0.
- SUB a=3, b=5 → r=0xFFFE, err=0. MULT a=0x0100, b=0x0100 → r=0x0000 (truncated), err=0.
- DIV a=1000, b=7 → out_valid exactly 17 cycles after accept, r=142, err=0. in_ready=0 throughout; a second in_valid pulse during DIV is ignored.
- DIV a=5, b=0 → r=0xFFFF, err=1 after 1 cycle. op=9 → r=0, err=1.
- Backpressure: out_ready=0 for 10 cycles after a result → r/err stable and in_ready=0; raising out_ready for one cycle → IDLE, in_ready=1 next cycle.
- rst_n pulsed low at cycle 8 of a DIV → out_valid=0, in_ready=1, r=0 immediately (asynchronous). The next ADD 2+2 returns 4. With ALU_REM_EN, REM 1000,7 → r=6 after 17 cycles.
